// File: rtl/sift_pkg.sv
// ============================================================================
//  Module   : sift_pkg
//  Purpose  : Shared constants and FSM state type for the sifting reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sift_pkg;
    localparam int ADDR_W_DEFAULT = 10;
    localparam int RAW_DEPTH      = 1 << ADDR_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sift_state_t;
endpackage

`default_nettype wire

// File: rtl/sift_reader_if.sv
// ============================================================================
//  Module   : sift_reader_if
//  Purpose  : Raw-store read bus plus sifted-key valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sift_reader_if
    import sift_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_bit;
    logic              mem_basis;
    logic              bob_basis;
    logic              key_bit;
    logic              key_valid;
    logic              key_ready;

    modport master (
        output mem_addr, key_bit, key_valid,
        input  mem_bit, mem_basis, bob_basis, key_ready
    );

    modport slave (
        input  mem_addr, key_bit, key_valid,
        output mem_bit, mem_basis, bob_basis, key_ready
    );
endinterface

`default_nettype wire

// File: rtl/sift_skid_fifo.sv
// ============================================================================
//  Module   : sift_skid_fifo
//  Purpose  : Two-entry 1-bit FIFO with push/pop/count; head is entry 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sift_skid_fifo (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire logic       i_din,
    input  wire logic       i_pop,
    output logic            o_dout,
    output logic            o_empty,
    output logic [1:0]      o_count
);
    logic [1:0] r_mem;
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem   <= 2'b00;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_mem[r_count[0]] <= i_din;
                    r_count           <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, queue shifts.
                    if (r_count == 2'd1) begin
                        r_mem[0] <= i_din;
                    end else begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout  = r_mem[0];
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/sift_reader.sv
// ============================================================================
//  Module   : sift_reader
//  Purpose  : Scans the raw-bit/basis stores and streams basis-matched bits.
//             Optional macro SIFT_DISCARD_COUNT_EN adds a discard counter port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sift_reader
    import sift_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            start,
    input  wire logic [ADDR_W:0] num_bits,
    sift_reader_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      sift_count
`ifdef SIFT_DISCARD_COUNT_EN
    ,
    output logic [ADDR_W:0]      discard_count
`endif
);
    localparam logic [ADDR_W:0] c_one = 1;

    sift_state_t       r_state;
    sift_state_t       w_next;
    logic [ADDR_W:0]   r_num;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_inflight;
    logic [ADDR_W:0]   r_sift_count;
    logic              w_issue;
    logic              w_match;
    logic              w_pop;
    logic              w_empty;
    logic              w_dout;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;

    // The pop honoured this cycle frees a slot, so a steady stream keeps one
    // read per cycle without ever exceeding the two FIFO entries.
    assign w_pop   = bus.key_valid && bus.key_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == SCAN) && (w_occ < 3'(FIFO_DEPTH));
    assign w_match = r_inflight && (bus.mem_basis == bus.bob_basis);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_bits == '0) ? FIN : SCAN;
            SCAN:    if (w_issue && (r_rd_ptr == r_num - c_one)) w_next = DRAIN;
            DRAIN:   if (!r_inflight && w_empty) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_num        <= '0;
            r_rd_ptr     <= '0;
            r_last_addr  <= '0;
            r_inflight   <= 1'b0;
            r_sift_count <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + c_one;
                r_last_addr <= r_rd_ptr[ADDR_W-1:0];
            end
            if ((r_state == IDLE) && start) begin
                r_num        <= num_bits;
                r_rd_ptr     <= '0;
                r_sift_count <= '0;
            end else if (w_match) begin
                r_sift_count <= r_sift_count + c_one;
            end
        end
    end

`ifdef SIFT_DISCARD_COUNT_EN
    logic [ADDR_W:0] r_discard_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_discard_count <= '0;
        end else if (r_inflight && !w_match) begin
            r_discard_count <= r_discard_count + c_one;
        end
    end

    assign discard_count = r_discard_count;
`endif

    sift_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_match),
        .i_din   (bus.mem_bit),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.mem_addr  = w_issue ? r_rd_ptr[ADDR_W-1:0] : r_last_addr;
    assign bus.key_valid = !w_empty;
    assign bus.key_bit   = w_dout;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == FIN);
    assign sift_count    = r_sift_count;
endmodule

`default_nettype wire

// File: tb/tb_sift_reader.sv
// ============================================================================
//  Module   : tb_sift_reader
//  Purpose  : Directed self-checking bench for sift_reader.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sift_reader;
    import sift_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_bits = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   sift_count;
`ifdef SIFT_DISCARD_COUNT_EN
    logic [AW:0]   discard_count;
`endif

    sift_reader_if #(.ADDR_W(AW)) bus ();

    sift_reader #(.ADDR_W(AW), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_bits      (num_bits),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
`ifdef SIFT_DISCARD_COUNT_EN
        .discard_count (discard_count),
`endif
        .sift_count    (sift_count)
    );

    always #5 clk = ~clk;

    bit a_bit [RAW_DEPTH];
    bit a_bas [RAW_DEPTH];
    bit b_bas [RAW_DEPTH];

    // Synchronous store model: one-cycle read latency.
    always @(posedge clk) begin
        bus.mem_bit   <= a_bit[bus.mem_addr];
        bus.mem_basis <= a_bas[bus.mem_addr];
        bus.bob_basis <= b_bas[bus.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    bit got_q[$];
    bit exp_q[$];
    int first_valid;
    int done_cyc;
    int max_addr;
    bit stall_ok;
    bit fin;

    task automatic check_idle(input string tag);
        chk({tag, "_mem_addr"},   64'(bus.mem_addr),  0);
        chk({tag, "_key_valid"},  64'(bus.key_valid), 0);
        chk({tag, "_key_bit"},    64'(bus.key_bit),   0);
        chk({tag, "_busy"},       64'(busy),          0);
        chk({tag, "_done"},       64'(done),          0);
        chk({tag, "_sift_count"}, 64'(sift_count),    0);
    endtask

    task automatic run(input int num, input int stall_at, input int stall_len, input int restart_at);
        int cyc;
        bit held_bit;
        logic [AW-1:0] held_addr;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < num; i++)
            if (a_bas[i] == b_bas[i]) exp_q.push_back(a_bit[i]);
        first_valid = -1;
        done_cyc    = -1;
        max_addr    = 0;
        stall_ok    = 1'b1;
        fin         = 1'b0;
        held_bit    = 1'b0;
        held_addr   = '0;
        @(negedge clk);
        num_bits = num[AW:0];
        start    = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!fin && cyc < 3000) begin
            bus.key_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == restart_at) begin
                start    = 1'b1;
                num_bits = num_bits + 11'd4;
            end else begin
                start = 1'b0;
            end
            #1;
            if (bus.key_valid && first_valid < 0) first_valid = cyc;
            if (bus.key_valid && bus.key_ready) got_q.push_back(bus.key_bit);
            if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
            if (done) begin
                fin      = 1'b1;
                done_cyc = cyc;
            end
            if (cyc == stall_at) begin
                held_bit  = bus.key_bit;
                held_addr = bus.mem_addr;
            end
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
                if (!bus.key_valid || bus.key_bit != held_bit || bus.mem_addr != held_addr)
                    stall_ok = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start         = 1'b0;
        bus.key_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int num, input int exp_sc);
        int mism;
        chk({tag, "_done_seen"}, 64'(fin), 1);
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) mism++;
        chk({tag, "_bits"}, 64'(mism), 0);
        chk({tag, "_sift_count"}, 64'(sift_count), 64'(exp_sc));
`ifdef SIFT_DISCARD_COUNT_EN
        chk({tag, "_discard_count"}, 64'(discard_count), 64'(num - exp_sc));
`endif
        #1;
        chk({tag, "_done_one_cycle"}, 64'(done), 0);
        chk({tag, "_busy_after"}, 64'(busy), 0);
    endtask

    initial begin
        int n;
        bit seen;
        bus.key_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // All bases equal, 8 positions.
        for (int i = 0; i < 8; i++) begin
            a_bit[i] = (8'b0100_1101 >> i) & 1;
            a_bas[i] = i[1];
            b_bas[i] = i[1];
        end
        run(8, -1, 0, -1);
        chk("s1_first_valid", 64'(first_valid), 3);
        check_stream("s1", 8, 8);

        // Bases match only on even addresses; Alice bits 1010...
        for (int i = 0; i < 16; i++) begin
            a_bit[i] = ~i[0];
            a_bas[i] = 1'b0;
            b_bas[i] = i[0];
        end
        run(16, -1, 0, -1);
        check_stream("s2", 16, 8);

        // Backpressure for 20 cycles mid-run.
        for (int i = 0; i < 8; i++) begin
            a_bit[i] = (8'b0100_1101 >> i) & 1;
            a_bas[i] = i[1];
            b_bas[i] = i[1];
        end
        run(8, 4, 20, -1);
        chk("s3_stall_stable", 64'(stall_ok), 1);
        check_stream("s3", 8, 8);

        // Empty scan.
        run(0, -1, 0, -1);
        chk("s4_zero_no_valid", 64'(first_valid), 64'(-1));
        chk("s4_zero_done_cyc", 64'(done_cyc), 1);
        check_stream("s4_zero", 0, 0);

        // Full-depth scan.
        for (int i = 0; i < RAW_DEPTH; i++) begin
            a_bit[i] = i[0] ^ i[3];
            a_bas[i] = i[2];
            b_bas[i] = i[2];
        end
        run(RAW_DEPTH, -1, 0, -1);
        chk("s4_full_max_addr", 64'(max_addr), 1023);
        check_stream("s4_full", RAW_DEPTH, RAW_DEPTH);

        // Reset mid-scan after 5 bits emitted.
        @(negedge clk);
        num_bits = 11'd16;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            if (bus.key_valid && bus.key_ready) n++;
            if (n < 5) @(negedge clk);
        end
        chk("s5_five_emitted", 64'(n), 5);
        chk("s5_busy_before", 64'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check_idle("s5_async");
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("s5_no_done", 64'(seen), 0);
        for (int i = 0; i < 4; i++) begin
            a_bit[i] = i[0];
            a_bas[i] = 1'b1;
            b_bas[i] = (i != 2);
        end
        run(4, -1, 0, -1);
        check_stream("s5_rerun", 4, 3);

        // Second start during SCAN must be ignored.
        for (int i = 0; i < 16; i++) begin
            a_bit[i] = i[1];
            a_bas[i] = 1'b0;
            b_bas[i] = (i == 5);
        end
        run(8, -1, 0, 3);
        check_stream("s6_restart", 8, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
